ntt_stage_sequencer: RTL and testbench

- Loop controller for the NTT datapath. On `start` it walks every stage span J and, for each stage, every butterfly-group/twiddle index pair.
- Each beat carries J and i. These feed the twiddle address generator directly.
- Each beat also carries the top/bottom coefficient-RAM base addresses for a D-lane butterfly array.
- This block is the initiator that drives the (i, J) consumer. Beats are delivered on a valid/ready handshake.

---
 rtl/ntt_stage_sequencer.sv | 141 ++++++++++++++
 tb/tb_ntt_stage_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ntt_stage_sequencer.sv
// ntt_stage_sequencer: loop controller for the NTT butterfly datapath.
// Walks every stage half-span J and, inside each stage, every (group, twiddle)
// pair, presenting one D-lane beat per handshake on a valid/ready interface.
//
// Build option: define NTT_SEQ_GS_EN for Gentleman-Sande stage order
// (J = 1 .. N/2). Left undefined, stages run Cooley-Tukey order (J = N/2 .. 1).
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; beat fields sit at their reset values
// RUN    | presenting beats, out_valid held high, advance on handshake
// DONE   | one-cycle done pulse after the final beat, busy still high
module ntt_stage_sequencer #(
  parameter int N    = 1024,
  parameter int D    = 4,
  parameter int LOGN = 10,
  parameter int IW   = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LOGN-1:0] J,
  output logic [IW-1:0]   i,
  output logic [LOGN-2:0] g,
  output logic [LOGN-1:0] addr_top,
  output logic [LOGN-1:0] addr_bot,
  output logic            stage_last,
  output logic            out_last
);

  localparam int LOGD = $clog2(D);
  localparam int SW   = $clog2(LOGN + 1);
  localparam int GW   = LOGN - 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // sh is log2(J) for the current stage
`ifdef NTT_SEQ_GS_EN
  localparam logic [SW-1:0] SH_FIRST = SW'(0);
  localparam logic [SW-1:0] SH_LAST  = SW'(LOGN - 1);
`else
  localparam logic [SW-1:0] SH_FIRST = SW'(LOGN - 1);
  localparam logic [SW-1:0] SH_LAST  = SW'(0);
`endif

  logic [1:0]    state;
  logic [SW-1:0] sh;
  logic [IW-1:0] beat;

  logic beat_fire;
  logic stage_end;
  logic xform_end;

  assign beat_fire = (state == S_RUN) && out_ready;
  // every stage is exactly 2^IW beats, so the counter's all-ones value ends it
  assign stage_end = (beat == '1);
  assign xform_end = stage_end && (sh == SH_LAST);

  // Control FSM plus stage / beat-in-stage counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      sh    <= SH_FIRST;
      beat  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= S_RUN;
        end
        S_RUN: begin
          if (beat_fire) begin
            beat <= beat + IW'(1);
            if (stage_end) begin
              if (sh == SH_LAST) begin
                state <= S_DONE;
                sh    <= SH_FIRST;
              end else begin
`ifdef NTT_SEQ_GS_EN
                sh <= sh + SW'(1);
`else
                sh <= sh - SW'(1);
`endif
              end
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  logic [LOGN-1:0] beat_w;
  logic [LOGN-1:0] j_w;
  logic [LOGN-1:0] top_w;
  logic [IW-1:0]   i_w;
  logic [GW-1:0]   g_w;
  logic [SW-1:0]   sub;

  // Beat fields decoded from (stage, beat) with shifts only. When J >= D the
  // beat splits into g (high bits) and i (low log2(J/D) bits); when J < D each
  // beat covers D/J whole groups, so g is the beat scaled up by D/J.
  always_comb begin
    beat_w = LOGN'(beat);
    j_w    = LOGN'(1) << sh;
    sub    = '0;
    i_w    = '0;
    g_w    = '0;
    if (sh >= SW'(LOGD)) begin
      sub = sh - SW'(LOGD);
      i_w = beat & IW'((LOGN'(1) << sub) - LOGN'(1));
      g_w = GW'(beat_w >> sub);
    end else begin
      sub = SW'(LOGD) - sh;
      g_w = GW'(beat_w << sub);
    end
    top_w = (LOGN'(g_w) << (sh + SW'(1))) + (LOGN'(i_w) << LOGD);
  end

  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign out_valid  = (state == S_RUN);
  assign J          = j_w;
  assign i          = i_w;
  assign g          = g_w;
  assign addr_top   = top_w;
  assign addr_bot   = top_w + j_w;
  assign stage_last = out_valid && stage_end;
  assign out_last   = out_valid && xform_end;

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
module tb_ntt_stage_sequencer;

  localparam int N    = 1024;
  localparam int D    = 4;
  localparam int LOGN = 10;
  localparam int IW   = 7;
  localparam int BEATS_PER_STAGE = N / (2 * D);
  localparam int TOTAL = LOGN * BEATS_PER_STAGE;

`ifdef NTT_SEQ_GS_EN
  localparam int J_RST = 1;
`else
  localparam int J_RST = N / 2;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            busy;
  logic            done;
  logic            out_valid;
  logic            out_ready;
  logic [LOGN-1:0] J;
  logic [IW-1:0]   i;
  logic [LOGN-2:0] g;
  logic [LOGN-1:0] addr_top;
  logic [LOGN-1:0] addr_bot;
  logic            stage_last;
  logic            out_last;

  ntt_stage_sequencer #(.N(N), .D(D), .LOGN(LOGN), .IW(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .J(J), .i(i), .g(g),
    .addr_top(addr_top), .addr_bot(addr_bot), .stage_last(stage_last),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  typedef struct {
    int j;
    int i;
    int g;
    int top;
    bit sl;
    bit ol;
  } beat_t;

  beat_t model[$];

  // Expected beat list straight from the loop rules: stage order, then
  // g-outer / i-inner for wide spans, or g stepping by D/J for narrow ones.
  task automatic build_model();
    beat_t b;
    int jj;
    int cnt;
    model.delete();
    for (int s = 0; s < LOGN; s++) begin
`ifdef NTT_SEQ_GS_EN
      jj = 1 << s;
`else
      jj = N >> (s + 1);
`endif
      cnt = 0;
      if (jj >= D) begin
        for (int gg = 0; gg < N / (2 * jj); gg++)
          for (int ii = 0; ii < jj / D; ii++) begin
            b.j = jj; b.i = ii; b.g = gg; b.top = gg * 2 * jj + ii * D;
            b.sl = (cnt == BEATS_PER_STAGE - 1); b.ol = 1'b0;
            model.push_back(b);
            cnt++;
          end
      end else begin
        for (int gg = 0; gg <= N / (2 * jj) - D / jj; gg += D / jj) begin
          b.j = jj; b.i = 0; b.g = gg; b.top = gg * 2 * jj;
          b.sl = (cnt == BEATS_PER_STAGE - 1); b.ol = 1'b0;
          model.push_back(b);
          cnt++;
        end
      end
    end
    model[model.size() - 1].ol = 1'b1;
  endtask

  task automatic check_rest(input string p);
    chk({p, "_valid"}, out_valid, 0);
    chk({p, "_J"}, J, J_RST);
    chk({p, "_i"}, i, 0);
    chk({p, "_g"}, g, 0);
    chk({p, "_top"}, addr_top, 0);
    chk({p, "_bot"}, addr_bot, J_RST);
    chk({p, "_sl"}, stage_last, 0);
    chk({p, "_ol"}, out_last, 0);
  endtask

  // One transform: start pulse, then beats under random ready, each accepted
  // beat compared with the model; optional start poke and mid-run reset.
  task automatic do_run(input int ready_pct, input int poke_at, input int rst_at);
    int idx;
    int cyc;
    bit hold;
    bit poked;
    logic [LOGN-1:0] h_j;
    logic [IW-1:0]   h_i;
    logic [LOGN-2:0] h_g;
    logic [LOGN-1:0] h_top;
    beat_t e;
    start = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk("first_valid", out_valid, 1);
    chk("first_busy", busy, 1);
    idx = 0; hold = 1'b0; poked = 1'b0;
    while (!done && cyc < 20000) begin
      chk("no_bubble", out_valid, 1);
      if (hold) begin
        chk("hold_J", J, h_j);
        chk("hold_i", i, h_i);
        chk("hold_g", g, h_g);
        chk("hold_top", addr_top, h_top);
      end
      if (idx == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_rest("midrst");
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        repeat (3) begin
          @(negedge clk);
          chk("midrst_no_done", done, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", busy, 0);
        return;
      end
      start = (idx == poke_at) && !poked;
      if (start) poked = 1'b1;
      out_ready = ($urandom_range(99) < ready_pct);
      hold = !out_ready;
      h_j = J; h_i = i; h_g = g; h_top = addr_top;
      if (out_ready) begin
        if (idx < model.size()) begin
          e = model[idx];
          chk($sformatf("b%0d_J", idx), J, e.j);
          chk($sformatf("b%0d_i", idx), i, e.i);
          chk($sformatf("b%0d_g", idx), g, e.g);
          chk($sformatf("b%0d_top", idx), addr_top, e.top);
          chk($sformatf("b%0d_bot", idx), addr_bot, e.top + e.j);
          chk($sformatf("b%0d_sl", idx), stage_last, e.sl);
          chk($sformatf("b%0d_ol", idx), out_last, e.ol);
        end else begin
          chk("extra_beat", idx, model.size());
        end
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    chk("done_seen", done, 1);
    chk("handshakes", idx, TOTAL);
    if (ready_pct >= 100) chk("start_to_done", cyc, TOTAL + 1);
    chk("done_busy", busy, 1);
    check_rest("done");
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    build_model();
    #12;
    check_rest("rst");
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_rest("idle");

    do_run(100, -1, -1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_drop", busy, 0);

    do_run(50, 300, -1);
    start = 1'b1;
    @(negedge clk);
    chk("start_in_done_busy", busy, 0);
    chk("start_in_done_valid", out_valid, 0);
    do_run(100, -1, -1);
    @(negedge clk);

    do_run(70, -1, 700);
    do_run(100, -1, -1);
    @(negedge clk);
    chk("final_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
